// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state codes and helpers for mux8_rr_arbiter
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot = N_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/data/grant bundle for mux8_rr_arbiter (lock only with MUX_ARB_LOCK_EN)
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       out;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;

  modport master (output req, in, lock, input gnt, sel, gnt_valid, out);
  modport slave  (input req, in, lock, output gnt, sel, gnt_valid, out);
`else
  modport master (output req, in, input gnt, sel, gnt_valid, out);
  modport slave  (input req, in, output gnt, sel, gnt_valid, out);
`endif
endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - first set bit of vec searching upward from start, wrapping 7->0
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] pos;

  // Scan farthest offset first so the nearest set bit is the final assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = start + SEL_W'(k);
      if (vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter with hold limit over a shared 8:1 1-bit mux
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses hold-limit preemption.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              rst,
  mux8_rr_arbiter_if.slave bus
);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] others, pick_vec;
  logic [SEL_W-1:0] pick_start, pick_idx;
  logic             pick_found, cur_req, hold_hit, lock_eff;

`ifdef MUX_ARB_LOCK_EN
  assign lock_eff = bus.lock;
`else
  assign lock_eff = 1'b0;
`endif

  assign others   = bus.req & ~onehot(sel_q);
  assign cur_req  = bus.req[sel_q];
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

  // One picker serves both states: full req from last+1 when idle, others from cur+1 when granted.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pick_vec   = bus.req;
      pick_start = last_q + 3'd1;
    end else begin
      pick_vec   = others;
      pick_start = sel_q + 3'd1;
    end
  end

  rr_pick8 u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          gnt_d       = onehot(pick_idx);
          sel_d       = pick_idx;
          gnt_valid_d = 1'b1;
          last_d      = pick_idx;
          hold_cnt_d  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if ((!cur_req || (hold_hit && !lock_eff)) && pick_found) begin
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = CNT_W'(1);
        end else if (!cur_req) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end else if (!hold_hit && (hold_cnt_q != '1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      gnt_valid_q <= 1'b0;
      last_q      <= 3'd7;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.out       = gnt_valid_q & bus.in[sel_q];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking bench: directed scenarios plus random traffic vs a reference model
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic       lock;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter_if ifa ();
  mux8_rr_arbiter_if ifb ();

  assign ifa.req = req;
  assign ifa.in  = din;
  assign ifb.req = req;
  assign ifb.in  = din;
`ifdef MUX_ARB_LOCK_EN
  assign ifa.lock = lock;
  assign ifb.lock = lock;
`endif

  mux8_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference model: granted index (-1 = idle), last winner, consecutive-hold count.
  int m_cur[2];
  int m_sel[2];
  int m_last[2];
  int m_cnt[2];
  int m_max[2] = '{8, 1};

  function automatic int pick(input logic [7:0] v, input int s);
    for (int k = 0; k < 8; k++)
      if (v[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i] = -1; m_sel[i] = 0; m_last[i] = 7; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] oth;
    int w;
    bit lk;
`ifdef MUX_ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      if (m_cur[i] < 0) begin
        w = pick(req, (m_last[i] + 1) % 8);
        if (w >= 0) begin m_cur[i] = w; m_sel[i] = w; m_last[i] = w; m_cnt[i] = 1; end
      end else begin
        oth = req;
        oth[m_cur[i]] = 1'b0;
        w = pick(oth, (m_cur[i] + 1) % 8);
        if (!req[m_cur[i]]) begin
          if (w >= 0) begin m_cur[i] = w; m_sel[i] = w; m_last[i] = w; m_cnt[i] = 1; end
          else begin m_cur[i] = -1; m_cnt[i] = 0; end
        end else if (m_max[i] != 0 && m_cnt[i] >= m_max[i]) begin
          if (!lk && w >= 0) begin m_cur[i] = w; m_sel[i] = w; m_last[i] = w; m_cnt[i] = 1; end
        end else if (m_cnt[i] < 15) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag, input int i, input logic [7:0] g,
                           input logic [2:0] s, input logic v, input logic o);
    logic [7:0] eg;
    logic       ev;
    ev = (m_cur[i] >= 0);
    eg = ev ? (8'd1 << m_cur[i]) : 8'd0;
    chk({tag, ".gnt"}, 32'(g), 32'(eg));
    chk({tag, ".sel"}, 32'(s), 32'(m_sel[i]));
    chk({tag, ".gnt_valid"}, 32'(v), 32'(ev));
    chk({tag, ".out"}, 32'(o), 32'(ev ? din[m_sel[i]] : 1'b0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model("a", 0, ifa.gnt, ifa.sel, ifa.gnt_valid, ifa.out);
    chk_model("b", 1, ifb.gnt, ifb.sel, ifb.gnt_valid, ifb.out);
  endtask

  // Called at a negedge: rst rises mid-cycle, outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.gnt", 32'(ifa.gnt), 32'h0);
    chk("rst.sel", 32'(ifa.sel), 32'h0);
    chk("rst.gnt_valid", 32'(ifa.gnt_valid), 32'h0);
    chk("rst.out", 32'(ifa.out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; din = 8'hFF; lock = 1'b0;
    model_reset();
    #2;
    chk("init.gnt", 32'(ifa.gnt), 32'h0);
    chk("init.gnt_valid", 32'(ifb.gnt_valid), 32'h0);
    chk("init.out", 32'(ifa.out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset: first search from 0, then reset in the middle of a grant.
    req = 8'h80; cycle();
    chk("t1.sel7", 32'(ifa.sel), 32'd7);
    req = 8'h08; cycle();
    chk("t1.sel3", 32'(ifa.sel), 32'd3);
    do_reset();
    req = 8'h80; cycle();
    chk("t1.after_rst_sel7", 32'(ifa.sel), 32'd7);

    // Rotation on the MAX_HOLD=1 instance.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("t2.rot_sel", 32'(ifb.sel), 32'(k % 8));
      chk("t2.onehot", 32'($onehot(ifb.gnt)), 32'd1);
    end

    // Hold limit of 8 between requesters 0 and 2.
    do_reset();
    req = 8'h05;
    for (int k = 0; k < 17; k++) begin
      cycle();
      chk("t3.hold_sel", 32'(ifa.sel), (k >= 8 && k < 16) ? 32'd2 : 32'd0);
    end

    // Single requester is never preempted.
    req = 8'h10;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("t4.single_sel", 32'(ifa.sel), 32'd4);
    end
    req = 8'h00; cycle();
    chk("t4.idle_valid", 32'(ifa.gnt_valid), 32'd0);

    // Release handoff without an idle bubble, then data path.
    req = 8'h08; cycle();
    chk("t5.sel3", 32'(ifa.sel), 32'd3);
    req = 8'h40; din = 8'h40; cycle();
    chk("t5.sel6", 32'(ifa.sel), 32'd6);
    chk("t5.valid", 32'(ifa.gnt_valid), 32'd1);
    chk("t5.out", 32'(ifa.out), 32'd1);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    req = 8'h03; lock = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t6.lock_sel", 32'(ifa.sel), 32'd0);
    end
    lock = 1'b0; cycle();
    chk("t6.unlock_sel", 32'(ifa.sel), 32'd1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) != 0) req = 8'($urandom) & 8'($urandom);
      din  = 8'($urandom);
      lock = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-to-1, 1-bit multiplexer datapath among 8 requesters.
- Registers a one-hot grant and the matching 3-bit select, and drives the muxed output bit.
- Enforces a per-grant hold limit so no requester starves the others.
- Sits between the requesting agents and the shared 8:1 select path; its sel output drives the mux select directly.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while others wait; 0 = unlimited. Must be < 2**CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i.
- in  input  8  data bits; in[i] belongs to requester i.
- gnt  output  8  registered one-hot grant; 0 when idle.
- sel  output  3  registered select, equal to the index of the gnt bit.
- gnt_valid  output  1  registered; 1 while any grant is active.
- out  output  1  combinational: in[sel] when gnt_valid, else 0.
- lock  input  1  present only with MUX_ARB_LOCK_EN.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All state clears immediately on rst=1, independent of clk.
- Reset values:
  - state=IDLE, gnt=0, sel=0, gnt_valid=0, out=0.
  - hold_cnt=0, last=7, so the first search starts at requester 0.
- Pick function: first set bit of a candidate vector, searching from start index s upward, wrapping 7->0.
- Latency: req sampled at edge N gives gnt/sel at edge N+1. No combinational path from req to gnt.
- IDLE state:
  - If req!=0: winner = pick(req, last+1); gnt<=onehot(winner), sel<=winner, gnt_valid<=1, last<=winner, hold_cnt<=1; go to GRANT.
  - Else: stay in IDLE; sel holds its previous value.
- GRANT state, with cur=sel and others = req with bit cur cleared:
  - Release (req[cur]=0) with others!=0: re-arbitrate from cur+1 and switch grant at the next edge with no idle bubble; hold_cnt<=1.
  - Release with others==0: go to IDLE; gnt<=0, gnt_valid<=0, hold_cnt<=0.
  - Hold limit (req[cur]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD) with others!=0: preempt, grant pick(others, cur+1), hold_cnt<=1.
  - Hold limit with others==0: keep the grant; hold_cnt saturates at MAX_HOLD.
  - Otherwise: keep the grant; hold_cnt<=hold_cnt+1, saturating at 2**CNT_W-1.
- last always tracks the most recent winner.
- A new grant never goes to the requester that just lost it while others are pending.
- Simultaneous release and new requests: the new requests are considered in that same cycle.
- Reset mid-grant: gnt drops asynchronously; the next arbitration starts from requester 0.
- out follows in[sel] combinationally; glitch-free switching is not required.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds the lock port.
  - While in GRANT with req[cur]=1 and lock=1, hold-limit preemption is suppressed and hold_cnt saturates at MAX_HOLD.
  - Release via req[cur]=0 still applies; lock is ignored in IDLE.
- Undefined: no lock port; behaviour is identical to lock tied to 0.

Decomposition:
- Shared package mux_arb_pkg holds:
  - constants N_REQ=8, SEL_W=3;
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
  - a function onehot(sel).
- Sub-module rr_pick8 (combinational):
  - inputs vec[7:0], start[2:0];
  - outputs idx[2:0], found.
  - Instantiated once. The candidate vector (req or others) and the start index are muxed per state.

Test Plan:
1. Reset: assert rst mid-cycle during a grant -> gnt=0, sel=0, gnt_valid=0, out=0 immediately; after release, req=8'h80 -> sel=7 one edge later.
2. Rotation: req=8'hFF held, MAX_HOLD=1 -> sel sequence 0,1,2,...,7,0 on consecutive cycles; gnt is always one-hot.
3. Hold limit: req=8'h05, MAX_HOLD=8 -> sel=0 for 8 cycles, then sel=2 for 8 cycles, then sel=0.
4. Single requester: req=8'h10 held 20 cycles -> sel=4 throughout, no preemption. Then req=0 -> gnt_valid=0 next edge.
5. Release handoff: grant on 3, drop req[3] while req[6]=1 -> next edge sel=6 with no idle cycle. Data check: in=8'h40 -> out=1.
6. Lock (with MUX_ARB_LOCK_EN): req=8'h03, lock=1 -> sel stays 0 beyond 8 cycles. lock=0 -> sel=1 on the next edge.
